// File: rtl/m_fetch_buf.sv
// Instruction fetch unit with a small {pc, instruction} queue toward decode.
// Keeps at most one memory request in flight; a redirect flushes the queue and drops any stale response.
module m_fetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic        w_mreq,
    output logic [31:0] w_maddr,
    input  logic        w_mack,
    input  logic [31:0] w_mdata,
    output logic        w_ovalid,
    output logic [31:0] w_oir,
    output logic [31:0] w_opc,
    input  logic        w_ordy,
    input  logic        w_redir,
    input  logic [31:0] w_rpc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];

    logic push, pop, flush;
    logic mreq_c;
    logic [31:0] maddr_c;

    assign mreq_c  = (state_q == S_IDLE) ? (count_q < DEPTH_C) : 1'b1;
    assign maddr_c = (state_q == S_IDLE) ? pc_q : addr_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (w_redir) begin
            flush = 1'b1;
            pc_d  = w_rpc;
            if (state_q == S_DISCARD) begin
                state_d = w_mack ? S_IDLE : S_DISCARD;
            end else if (mreq_c && !w_mack) begin
                // The request on the bus must still finish; its data will be dropped.
                state_d = S_DISCARD;
                addr_d  = maddr_c;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            pop = (count_q != '0) && w_ordy;
            case (state_q)
                S_IDLE: begin
                    if (mreq_c) begin
                        if (w_mack) begin
                            push = 1'b1;
                            pc_d = pc_q + 32'd4;
                        end else begin
                            state_d = S_REQ;
                            addr_d  = pc_q;
                        end
                    end
                end
                S_REQ: begin
                    if (w_mack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (w_mack) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            if (flush) begin
                count_q  <= '0;
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= maddr_c;
            ir_mem[wr_ptr_q] <= w_mdata;
        end
    end

    assign w_mreq   = mreq_c;
    assign w_maddr  = maddr_c;
    assign w_ovalid = (count_q != '0);
    assign w_opc    = pc_mem[rd_ptr_q];
    assign w_oir    = ir_mem[rd_ptr_q];

endmodule

// File: tb/tb_m_fetch_buf.sv
// Directed bench for m_fetch_buf: streaming, backpressure, slow memory, redirects and reset.
module tb_m_fetch_buf;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        w_mreq;
    logic [31:0] w_maddr;
    logic        w_mack;
    logic [31:0] w_mdata;
    logic        w_ovalid;
    logic [31:0] w_oir;
    logic [31:0] w_opc;
    logic        w_ordy;
    logic        w_redir;
    logic [31:0] w_rpc;

    int checks = 0;
    int errors = 0;

    m_fetch_buf #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_mreq  (w_mreq),
        .w_maddr (w_maddr),
        .w_mack  (w_mack),
        .w_mdata (w_mdata),
        .w_ovalid(w_ovalid),
        .w_oir   (w_oir),
        .w_opc   (w_opc),
        .w_ordy  (w_ordy),
        .w_redir (w_redir),
        .w_rpc   (w_rpc)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        w_rst = 1'b1; w_mack = 1'b0; w_mdata = '0; w_ordy = 1'b0;
        w_redir = 1'b0; w_rpc = '0;
        tick(); tick();
        chk("rst_ovalid", 32'(w_ovalid), 32'd0);
        chk("rst_mreq",   32'(w_mreq),   32'd1);
        chk("rst_maddr",  w_maddr,       32'h0);
        w_rst = 1'b0;

        // zero-wait streaming
        w_mack = 1'b1; w_ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stream_maddr", w_maddr, 32'(4 * i));
            w_mdata = memf(w_maddr);
            tick();
            chk("stream_opc", w_opc, 32'(4 * i));
            chk("stream_oir", w_oir, memf(32'(4 * i)));
        end

        // backpressure fills exactly DEPTH entries
        w_rst = 1'b1; tick(); w_rst = 1'b0;
        w_ordy = 1'b0; w_mack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_mreq", 32'(w_mreq), 32'd1);
            w_mdata = memf(w_maddr);
            tick();
        end
        chk("full_mreq", 32'(w_mreq), 32'd0);
        tick();
        chk("full_hold_opc", w_opc, 32'h0);
        chk("full_hold_mreq", 32'(w_mreq), 32'd0);
        w_ordy = 1'b1;
        tick();
        chk("resume_mreq", 32'(w_mreq), 32'd1);
        chk("resume_maddr", w_maddr, 32'h10);
        chk("resume_opc", w_opc, 32'h4);

        // slow memory: 3 wait cycles while queue drains
        w_mack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_mreq", 32'(w_mreq), 32'd1);
            chk("wait_maddr", w_maddr, 32'h10);
        end
        chk("wait_drained", 32'(w_ovalid), 32'd0);
        w_ordy = 1'b0; w_mack = 1'b1; w_mdata = memf(32'h10);
        tick();
        chk("ack_opc", w_opc, 32'h10);
        chk("ack_oir", w_oir, memf(32'h10));
        chk("ack_next_maddr", w_maddr, 32'h14);

        // redirect while a request is outstanding
        w_mack = 1'b0;
        tick();
        chk("req_maddr", w_maddr, 32'h14);
        w_redir = 1'b1; w_rpc = 32'h100;
        tick();
        w_redir = 1'b0;
        chk("disc_ovalid", 32'(w_ovalid), 32'd0);
        chk("disc_maddr", w_maddr, 32'h14);
        tick();
        w_mack = 1'b1; w_mdata = memf(32'h14);
        tick();
        chk("drop_ovalid", 32'(w_ovalid), 32'd0);
        chk("redir_maddr", w_maddr, 32'h100);
        w_mdata = memf(w_maddr);
        tick();
        chk("redir_opc", w_opc, 32'h100);

        // redirect coincident with an ack, 3 entries queued
        for (int i = 0; i < 2; i++) begin
            w_mdata = memf(w_maddr);
            tick();
        end
        chk("q3_head", w_opc, 32'h100);
        w_redir = 1'b1; w_rpc = 32'h200; w_ordy = 1'b1; w_mdata = memf(w_maddr);
        tick();
        w_redir = 1'b0;
        chk("flush_ovalid", 32'(w_ovalid), 32'd0);
        chk("flush_maddr", w_maddr, 32'h200);
        w_ordy = 1'b0; w_mdata = memf(w_maddr);
        tick();
        chk("post_flush_opc", w_opc, 32'h200);
        chk("post_flush_oir", w_oir, memf(32'h200));

        // reset during an outstanding request, with a redirect that must lose
        w_mack = 1'b0;
        tick();
        chk("pre_rst_maddr", w_maddr, 32'h204);
        w_rst = 1'b1; w_redir = 1'b1; w_rpc = 32'h300;
        tick();
        w_rst = 1'b0; w_redir = 1'b0;
        chk("post_rst_mreq", 32'(w_mreq), 32'd1);
        chk("post_rst_maddr", w_maddr, 32'h0);
        chk("post_rst_ovalid", 32'(w_ovalid), 32'd0);

        // w_ordy on an empty queue has no effect
        w_ordy = 1'b1;
        tick();
        chk("empty_ordy_ovalid", 32'(w_ovalid), 32'd0);
        w_mack = 1'b1; w_mdata = memf(32'h0);
        tick();
        chk("empty_ordy_opc", w_opc, 32'h0);
        chk("empty_ordy_valid", 32'(w_ovalid), 32'd1);

        // PC wraps modulo 2^32
        w_redir = 1'b1; w_rpc = 32'hFFFF_FFFC;
        tick();
        w_redir = 1'b0;
        chk("wrap_maddr0", w_maddr, 32'hFFFF_FFFC);
        w_mdata = memf(w_maddr);
        tick();
        chk("wrap_opc", w_opc, 32'hFFFF_FFFC);
        chk("wrap_maddr1", w_maddr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
